// File: rtl/ov7670_vga_readout.sv
// ov7670_vga_readout: scans the 320x240 RGB444 frame buffer, pixel/line-doubled onto 640x480@60 VGA
// with sync and blanked RGB delayed to match the buffer read latency.
module ov7670_vga_readout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FB_WIDTH   = 320,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [18:0] frame_addr,
  input  logic [11:0] frame_pixel,
  output logic [3:0]  vga_red,
  output logic [3:0]  vga_green,
  output logic [3:0]  vga_blue,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_done
);
  localparam int L       = RD_LATENCY + 2;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  logic [0:0]  r_state;
  logic [9:0]  r_h, r_v;
  logic [18:0] r_addr;
  logic [11:0] r_rgb;
  logic        r_done;
  logic [L-1:0] r_act, r_hs, r_vs;
  logic w_run, w_h_end, w_wrap, w_act, w_hs, w_vs;
  logic [8:0] w_x, w_y;
  assign w_run   = r_state == S_RUN;
  assign w_h_end = r_h == 10'(H_TOTAL - 1);
  assign w_wrap  = w_h_end && r_v == 10'(V_TOTAL - 1);
  assign w_act   = w_run && r_h < 10'(H_ACTIVE) && r_v < 10'(V_ACTIVE);
  assign w_hs    = !(w_run && r_h >= 10'(H_ACTIVE + H_FP) && r_h < 10'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs    = !(w_run && r_v >= 10'(V_ACTIVE + V_FP) && r_v < 10'(V_ACTIVE + V_FP + V_SYNC));
  assign w_x     = r_h[9:1];
  assign w_y     = r_v[9:1];
  // en only matters while idle or at the frame wrap, so a frame in flight always completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_h     <= '0;
      r_v     <= '0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_rgb   <= '0;
      r_act   <= '0;
      r_hs    <= '1;
      r_vs    <= '1;
    end else begin
      r_state <= (!w_run || w_wrap) ? (en ? S_RUN : S_IDLE) : r_state;
      r_h     <= (!w_run || w_h_end) ? 10'd0 : r_h + 10'd1;
      r_v     <= !w_run ? 10'd0 : w_h_end ? (w_wrap ? 10'd0 : r_v + 10'd1) : r_v;
      r_done  <= w_run && w_wrap;
      r_addr  <= w_act ? 19'(w_y) * 19'(FB_WIDTH) + 19'(w_x) : '0;
      r_act   <= {r_act[L-2:0], w_act};
      r_hs    <= {r_hs[L-2:0], w_hs};
      r_vs    <= {r_vs[L-2:0], w_vs};
      r_rgb   <= r_act[L-2] ? frame_pixel : '0;
    end
  end
  assign frame_addr = r_addr;
  assign {vga_red, vga_green, vga_blue} = r_rgb;
  assign vga_hsync  = r_hs[L-1];
  assign vga_vsync  = r_vs[L-1];
  assign frame_done = r_done;
endmodule
